vu_level_mapper: RTL and testbench

- Upstream feeder of the NeoPixel driver stage in the VU meter.
- Tracks the peak magnitude of incoming audio samples over a fixed frame window and converts it to a bar height with instant attack and slow decay.
- Serves a per-LED GRB colour word on the driver's LED-index request and triggers one strip refresh per frame via the driver's enable/ready handshake.

---
 rtl/vu_pkg.sv | 32 +++
 rtl/vu_peak_detect.sv | 55 +++++
 rtl/vu_level_mapper.sv | 188 ++++++++++++++++++
 tb/tb_vu_level_mapper.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vu_pkg.sv
// Shared state type and GRB colour helpers for the VU meter level mapper.
package vu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    UPDATE,
    REQUEST,
    WAIT_START,
    WAIT_DONE
  } vu_state_e;

  localparam int unsigned GRB_G_LSB = 16;
  localparam int unsigned GRB_R_LSB = 8;
  localparam int unsigned GRB_B_LSB = 0;

  function automatic logic [23:0] col_off();
    return '0;
  endfunction

  function automatic logic [23:0] col_green(input logic [7:0] bright);
    return 24'(bright) << GRB_G_LSB;
  endfunction

  function automatic logic [23:0] col_red(input logic [7:0] bright);
    return 24'(bright) << GRB_R_LSB;
  endfunction

  function automatic logic [23:0] col_yellow(input logic [7:0] bright);
    return col_green(bright) | col_red(bright);
  endfunction

endpackage

// File: rtl/vu_peak_detect.sv
// Sample magnitude with saturation, running peak accumulator and per-frame peak latch.
module vu_peak_detect
  import vu_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_sample_valid,
  input  logic [SAMPLE_W-1:0] i_sample,
  input  logic                i_frame_start,
  output logic [SAMPLE_W-2:0] o_frame_peak
);

  localparam int unsigned MAG_W = SAMPLE_W - 1;

  logic [MAG_W-1:0] mag;
  logic [MAG_W-1:0] acc_d, acc_q;
  logic [MAG_W-1:0] peak_d, peak_q;

  // Most negative input has no positive twin; clamp it to full scale.
  always_comb begin
    if (i_sample == {1'b1, {MAG_W{1'b0}}}) begin
      mag = '1;
    end else if (i_sample[SAMPLE_W-1]) begin
      mag = MAG_W'(~i_sample + 1'b1);
    end else begin
      mag = i_sample[MAG_W-1:0];
    end
  end

  always_comb begin
    acc_d  = acc_q;
    peak_d = peak_q;
    if (i_frame_start) begin
      peak_d = acc_q;
      acc_d  = i_sample_valid ? mag : '0;
    end else if (i_sample_valid && (mag > acc_q)) begin
      acc_d = mag;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_q  <= '0;
      peak_q <= '0;
    end else begin
      acc_q  <= acc_d;
      peak_q <= peak_d;
    end
  end

  assign o_frame_peak = peak_q;

endmodule

// File: rtl/vu_level_mapper.sv
// VU meter level mapper: frame peak -> bar height -> per-LED GRB colour, one refresh per frame.
// Optional peak-hold dot enabled by defining VU_PEAK_HOLD_EN.
module vu_level_mapper
  import vu_pkg::*;
#(
  parameter int unsigned LEDS         = 20,
  parameter int unsigned SAMPLE_W     = 16,
  parameter int unsigned FRAME_TICKS  = 800000,
  parameter int unsigned DECAY_FRAMES = 4,
  parameter int unsigned GREEN_END    = 12,
  parameter int unsigned RED_START    = 16,
  parameter logic [7:0]  BRIGHT       = 8'h20
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_sample_valid,
  input  logic [SAMPLE_W-1:0] i_sample,
  input  logic [7:0]          i_led_idx,
  input  logic                i_drv_rdy,
  output logic [23:0]         o_color_data,
  output logic                o_drv_en,
  output logic                o_busy
);

  localparam int unsigned MAG_W   = SAMPLE_W - 1;
  localparam int unsigned PROD_W  = MAG_W + 8;
  localparam int unsigned TMR_W   = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam int unsigned DCNT_W  = $clog2(DECAY_FRAMES + 1);
  localparam logic [7:0]  LEDS_L  = 8'(LEDS);
  localparam logic [7:0]  GREEN_L = 8'(GREEN_END);
  localparam logic [7:0]  RED_L   = 8'(RED_START);

  logic [TMR_W-1:0]  tmr_d, tmr_q;
  logic              frame_tick;
  vu_state_e         state_d, state_q;
  logic [MAG_W-1:0]  frame_peak;
  logic [PROD_W-1:0] prod, lvl_wide;
  logic [7:0]        lvl;
  logic [7:0]        bar_d, bar_q;
  logic [7:0]        disp_d, disp_q;
  logic [DCNT_W-1:0] dcnt_d, dcnt_q;
  logic              en_d, en_q;
  logic              busy_d, busy_q;
  logic [23:0]       color;

`ifdef VU_PEAK_HOLD_EN
  localparam int unsigned HT_W = $clog2(2 * DECAY_FRAMES + 1);
  logic [7:0]      hold_d, hold_q;
  logic [7:0]      hold_disp_d, hold_disp_q;
  logic [HT_W-1:0] htmr_d, htmr_q;
`endif

  always_comb begin
    frame_tick = (tmr_q == TMR_W'(FRAME_TICKS - 1));
    tmr_d      = frame_tick ? '0 : tmr_q + 1'b1;
  end

  vu_peak_detect #(
    .SAMPLE_W (SAMPLE_W)
  ) u_peak (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_sample_valid (i_sample_valid),
    .i_sample       (i_sample),
    .i_frame_start  (frame_tick && (state_q == IDLE)),
    .o_frame_peak   (frame_peak)
  );

  always_comb begin
    prod     = PROD_W'(frame_peak) * PROD_W'(LEDS + 1);
    lvl_wide = prod >> MAG_W;
    lvl      = (lvl_wide > PROD_W'(LEDS)) ? LEDS_L : lvl_wide[7:0];
  end

  // Ticks outside IDLE are ignored, so a busy driver drops the frame and the peak carries over.
  always_comb begin
    state_d = state_q;
    bar_d   = bar_q;
    dcnt_d  = dcnt_q;
    disp_d  = disp_q;
    en_d    = 1'b0;
    busy_d  = busy_q;
`ifdef VU_PEAK_HOLD_EN
    hold_d      = hold_q;
    hold_disp_d = hold_disp_q;
    htmr_d      = htmr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (frame_tick) state_d = UPDATE;
      end
      UPDATE: begin
        if (lvl >= bar_q) begin
          bar_d  = lvl;
          dcnt_d = '0;
        end else if (dcnt_q == DCNT_W'(DECAY_FRAMES - 1)) begin
          bar_d  = bar_q - 1'b1;
          dcnt_d = '0;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
        disp_d = bar_d;
`ifdef VU_PEAK_HOLD_EN
        if (bar_d > hold_q) begin
          hold_d = bar_d;
          htmr_d = HT_W'(2 * DECAY_FRAMES);
        end else if (htmr_q != '0) begin
          htmr_d = htmr_q - 1'b1;
        end else if (hold_q != '0) begin
          hold_d = hold_q - 1'b1;
        end
        hold_disp_d = hold_d;
`endif
        busy_d  = 1'b1;
        state_d = REQUEST;
      end
      REQUEST: begin
        if (i_drv_rdy) begin
          en_d    = 1'b1;
          state_d = WAIT_START;
        end
      end
      WAIT_START: begin
        if (!i_drv_rdy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (i_drv_rdy) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tmr_q   <= '0;
      state_q <= IDLE;
      bar_q   <= '0;
      dcnt_q  <= '0;
      disp_q  <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
`ifdef VU_PEAK_HOLD_EN
      hold_q      <= '0;
      hold_disp_q <= '0;
      htmr_q      <= '0;
`endif
    end else begin
      tmr_q   <= tmr_d;
      state_q <= state_d;
      bar_q   <= bar_d;
      dcnt_q  <= dcnt_d;
      disp_q  <= disp_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
`ifdef VU_PEAK_HOLD_EN
      hold_q      <= hold_d;
      hold_disp_q <= hold_disp_d;
      htmr_q      <= htmr_d;
`endif
    end
  end

  always_comb begin
    color = col_off();
    if ((i_led_idx < disp_q) && (i_led_idx < LEDS_L)) begin
      if (i_led_idx < GREEN_L) begin
        color = col_green(BRIGHT);
      end else if (i_led_idx < RED_L) begin
        color = col_yellow(BRIGHT);
      end else begin
        color = col_red(BRIGHT);
      end
    end
`ifdef VU_PEAK_HOLD_EN
    if ((hold_disp_q > disp_q) && (i_led_idx == hold_disp_q - 8'd1)) begin
      color = col_red(BRIGHT);
    end
`endif
  end

  assign o_color_data = color;
  assign o_drv_en     = en_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_vu_level_mapper.sv
// Self-checking bench for vu_level_mapper with a scoreboard of expected display snapshots.
`timescale 1ns/1ps
module tb_vu_level_mapper;
  import vu_pkg::*;

  localparam int LEDS = 20;
  localparam int DF   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [15:0] sample;
  logic [7:0]  idx;
  logic        rdy = 1'b1;
  logic [23:0] color;
  logic        en;
  logic        busy;

  always #5 clk = ~clk;

  vu_level_mapper #(
    .FRAME_TICKS  (100),
    .DECAY_FRAMES (DF)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_sample_valid (valid),
    .i_sample       (sample),
    .i_led_idx      (idx),
    .i_drv_rdy      (rdy),
    .o_color_data   (color),
    .o_drv_en       (en),
    .o_busy         (busy)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned en_count = 0;
  int unsigned rdy_cnt  = 0;
  bit          force_low = 1'b0;

  typedef struct {
    int disp;
    int hold;
  } exp_t;
  exp_t sb[$];

  int m_bar, m_dcnt, m_hold, m_htmr;

  // Driver model: ready drops the cycle after enable and stays low for 30 cycles.
  always @(negedge clk) begin
    if (force_low) begin
      rdy = 1'b0;
    end else if (rdy_cnt != 0) begin
      rdy_cnt--;
      if (rdy_cnt == 0) rdy = 1'b1;
    end else begin
      rdy = 1'b1;
    end
    if (en === 1'b1) begin
      en_count++;
      rdy     = 1'b0;
      rdy_cnt = 30;
    end
  end

  function automatic int mag_of(input logic [15:0] s);
    int v;
    v = int'($signed(s));
    if (v == -32768) return 32767;
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [23:0] exp_color(input int i, input int disp, input int hold);
    if (hold > disp && i == hold - 1) return 24'h002000;
    if (i >= disp || i >= LEDS) return 24'h000000;
    if (i < 12) return 24'h200000;
    if (i < 16) return 24'h202000;
    return 24'h002000;
  endfunction

  task automatic model_reset();
    m_bar = 0; m_dcnt = 0; m_hold = 0; m_htmr = 0;
    sb.delete();
  endtask

  task automatic model_frame(input int peak);
    int lvl;
    lvl = (peak * (LEDS + 1)) >> 15;
    if (lvl > LEDS) lvl = LEDS;
    if (lvl >= m_bar) begin
      m_bar = lvl; m_dcnt = 0;
    end else begin
      m_dcnt++;
      if (m_dcnt == DF) begin m_bar--; m_dcnt = 0; end
    end
`ifdef VU_PEAK_HOLD_EN
    if (m_bar > m_hold) begin
      m_hold = m_bar; m_htmr = 2 * DF;
    end else if (m_htmr != 0) begin
      m_htmr--;
    end else if (m_hold != 0) begin
      m_hold--;
    end
`endif
    sb.push_back('{m_bar, m_hold});
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic drive_sample(input logic [15:0] s);
    valid  = 1'b1;
    sample = s;
    @(negedge clk);
    valid  = 1'b0;
    sample = '0;
  endtask

  task automatic wait_busy(input logic lvl, input string name);
    int t = 0;
    while (busy !== lvl && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (busy !== lvl) begin
      n_checks++;
      $display("FAIL %s: o_busy timeout, got %b want %b", name, busy, lvl);
    end
  endtask

  // Consumer side of the scoreboard: one refresh completes, then the snapshot is scanned.
  task automatic finish_refresh(input int unsigned en_before, input string name);
    exp_t e;
    wait_busy(1'b0, name);
    n_checks++;
    if (en_count - en_before !== 1) $display("FAIL %s en_pulses: got %0d want 1", name, en_count - en_before);
    else n_pass++;
    if (sb.size() == 0) begin
      n_checks++;
      $display("FAIL %s scoreboard: no expected entry", name);
    end else begin
      e = sb.pop_front();
      for (int i = 0; i <= LEDS + 2; i++) begin
        int id;
        logic [23:0] want;
        id   = (i == LEDS + 2) ? 255 : i;
        idx  = 8'(id);
        #1;
        want = exp_color(id, e.disp, e.hold);
        n_checks++;
        if (color !== want) $display("FAIL %s color[%0d]: got %h want %h", name, id, color, want);
        else n_pass++;
      end
    end
    @(negedge clk);
  endtask

  task automatic refresh(input string name);
    int unsigned eb;
    wait_busy(1'b1, name);
    eb = en_count;
    finish_refresh(eb, name);
  endtask

  task automatic run_frame(input logic [15:0] s, input bit has_sample, input string name);
    if (has_sample) drive_sample(s);
    model_frame(has_sample ? mag_of(s) : 0);
    refresh(name);
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b0; sample = '0; idx = '0;
    cycles(3);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset busy: got %b want 0", busy); else n_pass++;
    n_checks++;
    if (en !== 1'b0) $display("FAIL reset en: got %b want 0", en); else n_pass++;
    n_checks++;
    if (dut.state_q !== IDLE) $display("FAIL reset state: got %0d want %0d", dut.state_q, IDLE); else n_pass++;
    idx = 8'd0; #1;
    n_checks++;
    if (color !== 24'h0) $display("FAIL reset color0: got %h want 000000", color); else n_pass++;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_full_scale();
    run_frame(16'h7FFF, 1'b1, "full_scale");
  endtask

  task automatic test_saturation();
    run_frame(16'h8000, 1'b1, "saturation");
    do_reset();
    run_frame(16'h4000, 1'b1, "half_scale");
  endtask

  task automatic test_peak_max();
    do_reset();
    drive_sample(16'd10000);
    drive_sample(16'hB1E0);
    drive_sample(16'd15000);
    model_frame(20000);
    refresh("peak_max");
  endtask

  task automatic test_decay();
    do_reset();
    run_frame(16'h7FFF, 1'b1, "decay_start");
    for (int f = 0; f < 8; f++) run_frame(16'h0, 1'b0, "decay");
  endtask

  task automatic test_drop_frame();
    int unsigned eb;
    do_reset();
    run_frame(16'h4000, 1'b1, "drop_pre");
    force_low = 1'b1;
    model_frame(0);
    wait_busy(1'b1, "drop_hold");
    eb = en_count;
    drive_sample(16'h7FFF);
    cycles(150);
    n_checks++;
    if (en_count !== eb) $display("FAIL drop no_en: got %0d pulses want 0", en_count - eb); else n_pass++;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL drop busy: got %b want 1", busy); else n_pass++;
    force_low = 1'b0;
    finish_refresh(eb, "drop_release");
    model_frame(32767);
    refresh("drop_carry");
  endtask

  task automatic test_reset_midrefresh();
    int unsigned eb;
    int t;
    drive_sample(16'h7FFF);
    wait_busy(1'b1, "midrst");
    eb = en_count;
    t = 0;
    while (en_count == eb && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (en_count == eb) begin
      n_checks++;
      $display("FAIL midrst en: got no pulse want 1");
    end
    cycles(3);
    n_checks++;
    if (dut.state_q !== WAIT_DONE) $display("FAIL midrst pre_state: got %0d want %0d", dut.state_q, WAIT_DONE); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (dut.state_q !== IDLE) $display("FAIL midrst state: got %0d want %0d", dut.state_q, IDLE); else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL midrst busy: got %b want 0", busy); else n_pass++;
    n_checks++;
    if (en !== 1'b0) $display("FAIL midrst en_out: got %b want 0", en); else n_pass++;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < LEDS; i++) begin
      idx = 8'(i);
      #1;
      n_checks++;
      if (color !== 24'h0) $display("FAIL midrst color[%0d]: got %h want 000000", i, color);
      else n_pass++;
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_full_scale();
    test_saturation();
    test_peak_max();
    test_decay();
    test_drop_frame();
    test_reset_midrefresh();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
